// File: rtl/dma_ctrl_pkg.sv
// Shared constants and types for the S2MM ping-pong DMA sequencer.
package dma_ctrl_pkg;

    // AXI DMA S2MM register offsets (simple mode)
    localparam logic [31:0] S2MM_DMACR  = 32'h0000_0030;
    localparam logic [31:0] S2MM_DMASR  = 32'h0000_0034;
    localparam logic [31:0] S2MM_DA     = 32'h0000_0048;
    localparam logic [31:0] S2MM_LENGTH = 32'h0000_0058;

    // Register values written by the sequencer
    localparam logic [31:0] DMACR_RUN_IRQ = 32'h0000_1001;  // RS=1, IOC_IrqEn=1
    localparam logic [31:0] DMACR_HALT    = 32'h0000_0000;
    localparam logic [31:0] DMASR_IOC_W1C = 32'h0000_1000;  // write-1-to-clear IOC

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_CR,
        WR_DA,
        WR_LEN,
        WAIT_IRQ,
        WR_ACK,
        WR_HALT,
        ERROR
    } state_t;

    // True for every state that performs exactly one AXI4-Lite write
    function automatic logic is_write_state(input state_t s);
        return (s == WR_CR) || (s == WR_DA) || (s == WR_LEN) ||
               (s == WR_ACK) || (s == WR_HALT);
    endfunction

endpackage

// File: rtl/dma_pingpong_ctrl_axil_single_writer.sv
// One-beat AXI4-Lite write engine: a req pulse launches AW and W together,
// each channel drops on its own handshake, B is accepted once both are done.
module axil_single_writer
    import dma_ctrl_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        done,
    output logic        slverr,
    output logic [31:0] m_axil_awaddr,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready
);

    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] data_q,    data_d;

    // Channel handshake tracking; addr/data are captured only on req so they stay stable while valid
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (req) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b0;
            addr_d    = addr;
            data_d    = data;
        end else begin
            if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
            if (bready_q && m_axil_bvalid) begin
                bready_d = 1'b0;
            end else if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) begin
                bready_d = 1'b1;
            end
        end
    end

    // State registers; reset drops every valid immediately
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign done           = bready_q && m_axil_bvalid;
    assign slverr         = done && (m_axil_bresp != RESP_OKAY);
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;

endmodule

// File: rtl/dma_pingpong_ctrl.sv
// Hardware sequencer running one AXI DMA S2MM channel in continuous ping-pong
// mode: program, wait for IOC, acknowledge, re-arm on the alternate buffer.
module dma_pingpong_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter logic [31:0] REG_BASE   = 32'h4000_0000,
    parameter logic [31:0] BUF_PING   = 32'hC000_0000,
    parameter logic [31:0] BUF_PONG   = 32'hC000_4000,
    parameter logic [25:0] XFER_BYTES = 26'd16384
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        stop,
    input  logic        dma_irq,
    output logic [31:0] m_axil_awaddr,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    output logic        buf_done,
    output logic        buf_idx,
    output logic        busy,
    output logic        err
);

    state_t      state_q, state_d;
    logic        cur_buf_q, cur_buf_d;
    logic        stop_pend_q, stop_pend_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        buf_done_q, buf_done_d;
    logic        buf_idx_q, buf_idx_d;

    logic        wr_req, wr_done, wr_slverr;
    logic [31:0] wr_addr, wr_data;

    // Next-state, stop latching and output decode for the sequencer
    always_comb begin
        state_d     = state_q;
        cur_buf_d   = cur_buf_q;
        stop_pend_d = stop_pend_q;
        err_d       = err_q;
        buf_done_d  = 1'b0;
        buf_idx_d   = buf_idx_q;

        // stop never aborts a transfer; it only schedules the halt after the next buffer
        if (stop && busy_q) stop_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WR_CR;
                    stop_pend_d = stop;
                end
            end
            WR_CR:   if (wr_done) state_d = wr_slverr ? ERROR : WR_DA;
            WR_DA:   if (wr_done) state_d = wr_slverr ? ERROR : WR_LEN;
            WR_LEN:  if (wr_done) state_d = wr_slverr ? ERROR : WAIT_IRQ;
            WAIT_IRQ: if (dma_irq) state_d = WR_ACK;
            WR_ACK: begin
                if (wr_done) begin
                    if (wr_slverr) begin
                        state_d = ERROR;
                    end else begin
                        buf_done_d = 1'b1;
                        buf_idx_d  = cur_buf_q;
                        cur_buf_d  = ~cur_buf_q;
                        state_d    = stop_pend_d ? WR_HALT : WR_DA;
                    end
                end
            end
            WR_HALT: begin
                if (wr_done) begin
                    state_d     = wr_slverr ? ERROR : IDLE;
                    stop_pend_d = 1'b0;
                end
            end
            ERROR: begin
                if (start) begin
                    state_d   = WR_CR;
                    err_d     = 1'b0;
                    cur_buf_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_slverr) err_d = 1'b1;

        busy_d = (state_d != IDLE) && (state_d != ERROR);
        wr_req = (state_d != state_q) && is_write_state(state_d);
    end

    // Register address/data for the write launched on entry to the next state
    always_comb begin
        wr_addr = REG_BASE + S2MM_DMACR;
        wr_data = DMACR_RUN_IRQ;
        case (state_d)
            WR_DA: begin
                wr_addr = REG_BASE + S2MM_DA;
                wr_data = cur_buf_d ? BUF_PONG : BUF_PING;
            end
            WR_LEN: begin
                wr_addr = REG_BASE + S2MM_LENGTH;
                wr_data = {6'b0, XFER_BYTES};
            end
            WR_ACK: begin
                wr_addr = REG_BASE + S2MM_DMASR;
                wr_data = DMASR_IOC_W1C;
            end
            WR_HALT: begin
                wr_addr = REG_BASE + S2MM_DMACR;
                wr_data = DMACR_HALT;
            end
            default: ;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cur_buf_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            buf_done_q  <= 1'b0;
            buf_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_buf_q   <= cur_buf_d;
            stop_pend_q <= stop_pend_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            buf_done_q  <= buf_done_d;
            buf_idx_q   <= buf_idx_d;
        end
    end

    axil_single_writer u_writer (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .req            (wr_req),
        .addr           (wr_addr),
        .data           (wr_data),
        .done           (wr_done),
        .slverr         (wr_slverr),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    assign buf_done = buf_done_q;
    assign buf_idx  = buf_idx_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dma_pingpong_ctrl.sv
// Directed bench for dma_pingpong_ctrl: an AXI4-Lite slave model records every
// completed write and flags protocol breaches; scenario tasks compare the log.
module tb_dma_pingpong_ctrl;

    logic        aclk, aresetn, start, stop, dma_irq;
    logic [31:0] m_axil_awaddr, m_axil_wdata;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid, m_axil_bready;
    logic        buf_done, buf_idx, busy, err;

    dma_pingpong_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .dma_irq(dma_irq),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready), .buf_done(buf_done), .buf_idx(buf_idx), .busy(busy), .err(err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // slave model state
    int          aw_delay = 0, w_delay = 0;
    int          aw_wait, w_wait, viol = 0, vcycles = 0;
    bit          aw_got, w_got, err_arm = 0;
    logic [31:0] err_addr = '0;
    logic [31:0] got_addr, got_data, awaddr_s, wdata_s;
    logic        awv_s, wv_s, brdy_s;
    logic [31:0] wa_q[$], wd_q[$];
    bit          bd_q[$];

    // Slave model: all decisions at negedge, where DUT outputs are stable
    initial begin
        bit aw_hs, w_hs;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
        awv_s = 0; wv_s = 0; brdy_s = 0; awaddr_s = '0; wdata_s = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 2'b00;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
                awv_s = 0; wv_s = 0; brdy_s = 0;
                continue;
            end
            aw_hs = m_axil_awready && awv_s;
            w_hs  = m_axil_wready && wv_s;
            if (aw_hs) begin aw_got = 1; got_addr = awaddr_s; end
            if (w_hs)  begin w_got = 1;  got_data = wdata_s;  end
            if (m_axil_bvalid && brdy_s) begin
                wa_q.push_back(got_addr);
                wd_q.push_back(got_data);
                m_axil_bvalid = 0; m_axil_bresp = 2'b00;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
            end
            if (awv_s && !aw_hs && (!m_axil_awvalid || m_axil_awaddr !== awaddr_s)) viol++;
            if (wv_s && !w_hs && (!m_axil_wvalid || m_axil_wdata !== wdata_s)) viol++;
            if (m_axil_awvalid && aw_got) viol++;
            if (m_axil_wvalid && w_got) viol++;
            if (m_axil_bready && !(aw_got && w_got)) viol++;
            if (m_axil_wstrb !== 4'hF) viol++;
            if (m_axil_awvalid || m_axil_wvalid) vcycles++;
            if (buf_done) bd_q.push_back(buf_idx);
            if (m_axil_awvalid && !aw_got) begin aw_wait++; m_axil_awready = (aw_wait > aw_delay); end
            else m_axil_awready = 0;
            if (m_axil_wvalid && !w_got) begin w_wait++; m_axil_wready = (w_wait > w_delay); end
            else m_axil_wready = 0;
            if (aw_got && w_got && !m_axil_bvalid) begin
                m_axil_bvalid = 1;
                if (err_arm && got_addr == err_addr) begin m_axil_bresp = 2'b10; err_arm = 0; end
                else m_axil_bresp = 2'b00;
            end
            awv_s = m_axil_awvalid; awaddr_s = m_axil_awaddr;
            wv_s  = m_axil_wvalid;  wdata_s  = m_axil_wdata;
            brdy_s = m_axil_bready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    function automatic logic [31:0] log_a(input int i);
        return (i < wa_q.size()) ? wa_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] log_d(input int i);
        return (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic pulse_start(input logic with_stop);
        start = 1; stop = with_stop;
        tick();
        start = 0; stop = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wa_q.size() < n && k < budget) begin tick(); k++; end
        n_vec++;
        if (wa_q.size() < n) begin
            n_err++;
            $display("FAIL wait_writes: got %0d writes, required %0d", wa_q.size(), n);
        end
    endtask

    // Raise the level irq after a delay and hold it until the DMASR clear completes
    task automatic raise_irq(input int delay);
        int n0 = wa_q.size();
        int k = 0;
        repeat (delay) tick();
        dma_irq = 1;
        while (wa_q.size() <= n0 && k < 300) begin tick(); k++; end
        dma_irq = 0;
        n_vec++;
        if (wa_q.size() <= n0) begin
            n_err++;
            $display("FAIL irq_ack: got %0d writes, required > %0d", wa_q.size(), n0);
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        aresetn = 0; start = 0; stop = 0; dma_irq = 0;
        repeat (3) tick();
        obs = {m_axil_awvalid, m_axil_wvalid, m_axil_bready, buf_done, buf_idx, busy, err, m_axil_wstrb};
        n_vec++;
        if (obs !== 11'h00F) begin n_err++; $display("FAIL reset_outputs: got %h, expected %h", obs, 11'h00F); end
        aresetn = 1;
        repeat (5) tick();
        obs = {m_axil_awvalid, m_axil_wvalid, m_axil_bready, buf_done, buf_idx, busy, err, m_axil_wstrb};
        n_vec++;
        if (obs !== 11'h00F || wa_q.size() != 0) begin
            n_err++; $display("FAIL idle_after_reset: got %h/%0d writes, expected %h/0", obs, wa_q.size(), 11'h00F);
        end
    endtask

    task automatic test_start();
        int n0 = wa_q.size();
        logic [31:0] ea[3], ed[3];
        ea = '{32'h4000_0030, 32'h4000_0048, 32'h4000_0058};
        ed = '{32'h0000_1001, 32'hC000_0000, 32'd16384};
        pulse_start(0);
        wait_writes(n0 + 3, 100);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (log_a(n0 + i) !== ea[i] || log_d(n0 + i) !== ed[i]) begin
                n_err++;
                $display("FAIL start_write%0d: got (%h,%h), expected (%h,%h)", i, log_a(n0 + i), log_d(n0 + i), ea[i], ed[i]);
            end
        end
        repeat (20) tick();
        n_vec++;
        if (busy !== 1'b1 || wa_q.size() != n0 + 3 || bd_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_irq_idle: got busy=%b writes=%0d buf_done=%0d, expected 1/%0d/0", busy, wa_q.size(), bd_q.size(), n0 + 3);
        end
    endtask

    task automatic test_pingpong();
        int n0, b0;
        logic [31:0] ea[3], ed[3];
        for (int r = 0; r < 2; r++) begin
            n0 = wa_q.size(); b0 = bd_q.size();
            ea = '{32'h4000_0034, 32'h4000_0048, 32'h4000_0058};
            ed = '{32'h0000_1000, (r == 0) ? 32'hC000_4000 : 32'hC000_0000, 32'd16384};
            raise_irq(50);
            wait_writes(n0 + 3, 100);
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (log_a(n0 + i) !== ea[i] || log_d(n0 + i) !== ed[i]) begin
                    n_err++;
                    $display("FAIL pingpong%0d_write%0d: got (%h,%h), expected (%h,%h)", r, i, log_a(n0 + i), log_d(n0 + i), ea[i], ed[i]);
                end
            end
            n_vec++;
            if (bd_q.size() != b0 + 1 || (bd_q.size() > b0 && bd_q[b0] != r[0])) begin
                n_err++;
                $display("FAIL pingpong%0d_buf_done: got %0d pulses, expected 1 with idx %0d", r, bd_q.size() - b0, r);
            end
        end
    endtask

    task automatic test_stop();
        int n0, b0;
        // buffer 0 completes, buffer 1 armed
        n0 = wa_q.size();
        raise_irq(10);
        wait_writes(n0 + 3, 100);
        n_vec++;
        if (log_d(n0 + 1) !== 32'hC000_4000) begin
            n_err++; $display("FAIL stop_prearm_da: got %h, expected %h", log_d(n0 + 1), 32'hC000_4000);
        end
        n0 = wa_q.size(); b0 = bd_q.size();
        repeat (5) tick();
        pulse_stop();
        repeat (10) tick();
        n_vec++;
        if (wa_q.size() != n0 || busy !== 1'b1) begin
            n_err++; $display("FAIL stop_no_abort: got writes=%0d busy=%b, expected %0d/1", wa_q.size(), busy, n0);
        end
        raise_irq(5);
        wait_writes(n0 + 2, 100);
        repeat (10) tick();
        n_vec++;
        if (log_a(n0 + 1) !== 32'h4000_0030 || log_d(n0 + 1) !== 32'h0) begin
            n_err++; $display("FAIL stop_halt_write: got (%h,%h), expected (40000030,00000000)", log_a(n0 + 1), log_d(n0 + 1));
        end
        n_vec++;
        if (busy !== 1'b0 || wa_q.size() != n0 + 2 || bd_q.size() != b0 + 1 || (bd_q.size() > b0 && bd_q[b0] != 1'b1)) begin
            n_err++; $display("FAIL stop_idle: got busy=%b writes=%0d pulses=%0d, expected 0/%0d/1 idx 1", busy, wa_q.size(), bd_q.size() - b0, n0 + 2);
        end
        n0 = wa_q.size();
        pulse_start(0);
        wait_writes(n0 + 3, 100);
        n_vec++;
        if (log_a(n0) !== 32'h4000_0030 || log_d(n0 + 1) !== 32'hC000_0000) begin
            n_err++; $display("FAIL restart_order: got CR %h DA %h, expected 40000030/c0000000", log_a(n0), log_d(n0 + 1));
        end
    endtask

    task automatic test_slave_delay();
        int n0 = wa_q.size();
        int b0 = bd_q.size();
        int v0 = viol;
        logic [31:0] ed[6];
        ed = '{32'h0000_1000, 32'hC000_4000, 32'd16384, 32'h0000_1000, 32'hC000_0000, 32'd16384};
        aw_delay = 3; w_delay = 7;
        raise_irq(10);
        wait_writes(n0 + 3, 200);
        aw_delay = 7; w_delay = 3;
        raise_irq(10);
        wait_writes(n0 + 6, 200);
        repeat (5) tick();
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (log_d(n0 + i) !== ed[i]) begin
                n_err++; $display("FAIL delay_write%0d: got %h, expected %h", i, log_d(n0 + i), ed[i]);
            end
        end
        n_vec++;
        if (viol != v0 || wa_q.size() != n0 + 6) begin
            n_err++; $display("FAIL delay_protocol: got %0d breaches, %0d writes, expected 0/%0d", viol - v0, wa_q.size(), n0 + 6);
        end
        aw_delay = 0; w_delay = 0;
        pulse_stop();
        raise_irq(5);
        wait_writes(n0 + 8, 100);
        repeat (5) tick();
        n_vec++;
        if (busy !== 1'b0 || bd_q.size() != b0 + 3 || log_d(n0 + 7) !== 32'h0) begin
            n_err++; $display("FAIL delay_halt: got busy=%b pulses=%0d halt=%h, expected 0/3/00000000", busy, bd_q.size() - b0, log_d(n0 + 7));
        end
    endtask

    task automatic test_error();
        int n0 = wa_q.size();
        int b0 = bd_q.size();
        int v0;
        err_arm = 1; err_addr = 32'h4000_0048;
        pulse_start(0);
        wait_writes(n0 + 2, 100);
        repeat (3) tick();
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL error_entry: got err=%b busy=%b, expected 1/0", err, busy);
        end
        v0 = vcycles;
        pulse_stop();
        dma_irq = 1;
        repeat (20) tick();
        dma_irq = 0;
        n_vec++;
        if (vcycles != v0 || wa_q.size() != n0 + 2 || bd_q.size() != b0 || err !== 1'b1) begin
            n_err++; $display("FAIL error_quiet: got valid_cycles=%0d writes=%0d pulses=%0d err=%b, expected 0/%0d/0/1", vcycles - v0, wa_q.size(), bd_q.size() - b0, err, n0 + 2);
        end
        pulse_start(0);
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL error_clear: got err=%b, expected 0", err); end
        n0 = wa_q.size();
        wait_writes(n0 + 3, 100);
        n_vec++;
        if (log_a(n0) !== 32'h4000_0030 || log_d(n0) !== 32'h0000_1001 || log_d(n0 + 1) !== 32'hC000_0000) begin
            n_err++; $display("FAIL error_restart: got CR (%h,%h) DA %h, expected (40000030,00001001) c0000000", log_a(n0), log_d(n0), log_d(n0 + 1));
        end
        pulse_stop();
        raise_irq(5);
        wait_writes(n0 + 5, 100);
        repeat (5) tick();
    endtask

    task automatic test_start_stop_reset();
        int n0 = wa_q.size();
        int b0 = bd_q.size();
        int k = 0;
        logic [3:0] obs;
        pulse_start(1);
        wait_writes(n0 + 3, 100);
        raise_irq(10);
        wait_writes(n0 + 5, 100);
        repeat (10) tick();
        n_vec++;
        if (log_d(n0 + 1) !== 32'hC000_4000 || log_d(n0 + 4) !== 32'h0 || wa_q.size() != n0 + 5) begin
            n_err++; $display("FAIL startstop_writes: got DA %h halt %h count %0d, expected c0004000/00000000/%0d", log_d(n0 + 1), log_d(n0 + 4), wa_q.size(), n0 + 5);
        end
        n_vec++;
        if (busy !== 1'b0 || bd_q.size() != b0 + 1 || (bd_q.size() > b0 && bd_q[b0] != 1'b1)) begin
            n_err++; $display("FAIL startstop_once: got busy=%b pulses=%0d, expected 0/1 idx 1", busy, bd_q.size() - b0);
        end
        // run buffer 0, then reset during the DA write that re-arms buffer 1
        n0 = wa_q.size();
        pulse_start(0);
        wait_writes(n0 + 3, 100);
        aw_delay = 6; w_delay = 6;
        raise_irq(5);
        while (!m_axil_awvalid && k < 50) begin tick(); k++; end
        n_vec++;
        if (m_axil_awvalid !== 1'b1 || m_axil_awaddr !== 32'h4000_0048) begin
            n_err++; $display("FAIL pre_reset_write: got awvalid=%b addr=%h, expected 1/40000048", m_axil_awvalid, m_axil_awaddr);
        end
        @(posedge aclk);
        #2;
        aresetn = 0;
        #1;
        obs = {m_axil_awvalid, m_axil_wvalid, m_axil_bready, busy};
        n_vec++;
        if (obs !== 4'b0000) begin n_err++; $display("FAIL async_reset_drop: got %b, expected 0000", obs); end
        repeat (3) tick();
        aresetn = 1;
        aw_delay = 0; w_delay = 0;
        n0 = wa_q.size();
        repeat (10) tick();
        n_vec++;
        if (busy !== 1'b0 || wa_q.size() != n0) begin
            n_err++; $display("FAIL post_reset_idle: got busy=%b writes=%0d, expected 0/%0d", busy, wa_q.size(), n0);
        end
        pulse_start(0);
        wait_writes(n0 + 3, 100);
        n_vec++;
        if (log_d(n0 + 1) !== 32'hC000_0000) begin
            n_err++; $display("FAIL post_reset_da: got %h, expected c0000000", log_d(n0 + 1));
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pingpong();
        test_stop();
        test_slave_delay();
        test_error();
        test_start_stop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
